mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Multiply/divide-side execution unit: a multi-cycle multiplier plus the architectural HI/LO registers.
- Consumes the MULT/MULTU/MUL/MTHI/MTLO/MFHI/MFLO operations the decode stage issues, with fully forwarded reg1/reg2 operands.
- Sits beside the EX stage. Raises a stall to the pipeline control while a multiply runs and returns 32-bit results for MFHI/MFLO/MUL to the EX result mux.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits, the product is 2*WIDTH.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- valid_i  in  1  op_i/reg1_i/reg2_i carry an issued operation this cycle.
- op_i  in  3  0 none, 1 MULT, 2 MULTU, 3 MUL, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
- reg1_i  in  WIDTH  rs operand (multiplicand; MTHI/MTLO source).
- reg2_i  in  WIDTH  rt operand (multiplier).
- flush_i  in  1  abort any in-flight multiply.
- stall_o  out  1  pipeline must hold the current EX instruction.
- result_o  out  WIDTH  MFHI/MFLO/MUL result.
- result_valid_o  out  1  result_o is valid this cycle.
- hi_o  out  WIDTH  architectural HI.
- lo_o  out  WIDTH  architectural LO.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; hi_o, lo_o, accumulator, counter and sign flag = 0; stall_o=0; result_valid_o=0; result_o=0.
- States IDLE, RUN, DONE.
- IDLE, valid_i with op MULT/MULTU/MUL:
  - Capture operands. For MULT/MUL take two's-complement absolute values and set sign = reg1_i[31]^reg2_i[31]; for MULTU sign=0.
  - Clear the 64-bit accumulator and the counter; go to RUN.
  - stall_o=1 combinationally in this cycle.
- IDLE, valid_i with MTHI/MTLO: hi/lo <= reg1_i at the next edge; no stall.
- IDLE, valid_i with MFHI/MFLO: result_o = hi_o/lo_o combinationally; result_valid_o=1 the same cycle. Registered HI/LO, so MTHI at cycle t followed by MFHI at t+1 returns the new value.
- RUN, each cycle:
  - If multiplier[0]=1, acc += 64-bit zero-extended multiplicand.
  - Multiplicand <<= 1; multiplier >>= 1; counter++.
  - After 32 RUN cycles (counter==31 at the edge) go to DONE.
  - stall_o=1 throughout. valid_i/op_i are ignored; upstream holds them stable.
- DONE, one cycle:
  - product = sign ? -acc : acc, mod 2^64. abs(0x80000000) is 0x80000000 unsigned, so the result is correct.
  - MULT/MULTU: {hi,lo} <= product at the edge ending DONE.
  - MUL: result_o = product[31:0], result_valid_o=1; HI/LO unchanged.
  - stall_o=0 so the pipeline advances. The held valid_i does not restart a multiply. Next state is IDLE unconditionally.
- Latency: start at cycle t; RUN t+1..t+32; DONE t+33; stall_o high t..t+32 (33 cycles); HI/LO visible on hi_o/lo_o at t+34.
- result_valid_o=0 in all other cycles; result_o holds its last value when not valid.
- flush_i:
  - In RUN or DONE: next state IDLE, no HI/LO write, stall_o=0 from the cycle after flush_i.
  - Asserted in IDLE together with valid_i: the operation is dropped, including MTHI/MTLO writes.
- op_i=0 with valid_i=1: no effect.
- Reset asserted mid-RUN: immediate return to IDLE with all registers zero; no partial HI/LO write.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> stall_o high exactly 33 cycles; hi_o=0xFFFFFFFE, lo_o=0x00000001 at t+34.
- MULT 0xFFFFFFFD (-3) * 0x00000007 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB.
- MULT 0x80000000*0x80000000 -> hi_o=0x40000000, lo_o=0x00000000; MULT 0x80000000*0x00000001 -> hi_o=0xFFFFFFFF, lo_o=0x80000000.
- MTHI 0x12345678, MTLO 0x9ABCDEF0, then MUL 0x00010003*0x00010000 -> result_o=0x00030000 with result_valid_o=1 in DONE only; hi_o/lo_o remain 0x12345678/0x9ABCDEF0.
- MTHI 0xDEADBEEF at cycle t, MFHI at t+1 -> result_o=0xDEADBEEF, result_valid_o=1 at t+1, no stall.
- MULTU started with HI/LO=0x11111111/0x22222222; flush_i at RUN cycle 10 -> stall_o low next cycle, HI/LO unchanged. Repeat the same multiply with rst pulled low mid-RUN -> hi_o=lo_o=0, stall_o=0 immediately.

Source files
------------

// File: rtl/mdu_hilo.sv
// Multiply-side execution unit: 32-iteration shift-add multiplier plus the
// architectural HI/LO registers. Handles MULT/MULTU/MUL/MTHI/MTLO/MFHI/MFLO.
// Signed multiplies run on absolute values; the sign is reapplied in DONE.
module mdu_hilo #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] reg1_i,
    input  logic [WIDTH-1:0] reg2_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic [WIDTH-1:0] result_o,
    output logic             result_valid_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MUL   = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MFHI  = 3'd6;
    localparam logic [2:0] OP_MFLO  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [2*WIDTH-1:0]     mcand_reg, mcand_next;
    logic [WIDTH-1:0]       mplier_reg, mplier_next;
    logic [2*WIDTH-1:0]     acc_reg, acc_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   sign_reg, sign_next;
    logic                   mul_reg, mul_next;     // MUL: result to EX, HI/LO untouched
    logic [WIDTH-1:0]       hi_reg, hi_next;
    logic [WIDTH-1:0]       lo_reg, lo_next;
    logic [WIDTH-1:0]       res_reg, res_next;     // last result, held when not valid

    logic                   signed_op;
    logic [WIDTH-1:0]       abs1, abs2;
    logic [2*WIDTH-1:0]     product;

    // Operand conditioning: signed ops multiply magnitudes. abs(most-negative)
    // wraps to itself, which is still the right unsigned magnitude.
    assign signed_op = (op_i == OP_MULT) || (op_i == OP_MUL);
    assign abs1      = (signed_op && reg1_i[WIDTH-1]) ? -reg1_i : reg1_i;
    assign abs2      = (signed_op && reg2_i[WIDTH-1]) ? -reg2_i : reg2_i;
    assign product   = sign_reg ? -acc_reg : acc_reg;

    assign hi_o = hi_reg;
    assign lo_o = lo_reg;

    // Next-state, datapath updates and combinational outputs
    always_comb begin
        state_next     = state_reg;
        mcand_next     = mcand_reg;
        mplier_next    = mplier_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        sign_next      = sign_reg;
        mul_next       = mul_reg;
        hi_next        = hi_reg;
        lo_next        = lo_reg;
        res_next       = res_reg;
        stall_o        = 1'b0;
        result_valid_o = 1'b0;
        result_o       = res_reg;

        case (state_reg)
            ST_IDLE: begin
                // A flush in the issue cycle drops the operation entirely
                if (valid_i && !flush_i) begin
                    case (op_i)
                        OP_MULT, OP_MULTU, OP_MUL: begin
                            mcand_next  = {{WIDTH{1'b0}}, abs1};
                            mplier_next = abs2;
                            acc_next    = '0;
                            cnt_next    = '0;
                            sign_next   = signed_op & (reg1_i[WIDTH-1] ^ reg2_i[WIDTH-1]);
                            mul_next    = (op_i == OP_MUL);
                            stall_o     = 1'b1;
                            state_next  = ST_RUN;
                        end
                        OP_MTHI: hi_next = reg1_i;
                        OP_MTLO: lo_next = reg1_i;
                        OP_MFHI: begin
                            result_o       = hi_reg;
                            result_valid_o = 1'b1;
                            res_next       = hi_reg;
                        end
                        OP_MFLO: begin
                            result_o       = lo_reg;
                            result_valid_o = 1'b1;
                            res_next       = lo_reg;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    state_next = ST_IDLE;
                end else begin
                    if (mplier_reg[0]) begin
                        acc_next = acc_reg + mcand_reg;
                    end
                    mcand_next  = mcand_reg << 1;
                    mplier_next = mplier_reg >> 1;
                    cnt_next    = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(WIDTH-1)) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Held valid_i must not restart: always return to IDLE
                state_next = ST_IDLE;
                if (!flush_i) begin
                    if (mul_reg) begin
                        result_o       = product[WIDTH-1:0];
                        result_valid_o = 1'b1;
                        res_next       = product[WIDTH-1:0];
                    end else begin
                        hi_next = product[2*WIDTH-1:WIDTH];
                        lo_next = product[WIDTH-1:0];
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and datapath registers, cleared by asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            sign_reg   <= 1'b0;
            mul_reg    <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            res_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            sign_reg   <= sign_next;
            mul_reg    <= mul_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            res_reg    <= res_next;
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed testbench for mdu_hilo with hand-computed expected values.
module tb_mdu_hilo;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [2:0]  op_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic        flush_i;
    logic        stall_o;
    logic [31:0] result_o;
    logic        result_valid_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_hilo #(.WIDTH(32), .CNT_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_i        (valid_i),
        .op_i           (op_i),
        .reg1_i         (reg1_i),
        .reg2_i         (reg2_i),
        .flush_i        (flush_i),
        .stall_o        (stall_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .hi_o           (hi_o),
        .lo_o           (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a multiply at cycle t, count stall cycles, check DONE and HI/LO at t+34
    task automatic run_mult(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] exp_hilo,
                            input logic is_mul, input logic [31:0] exp_res);
        int n;
        valid_i = 1'b1;
        op_i    = op;
        reg1_i  = a;
        reg2_i  = b;
        #1;
        chk({tag, " stall_start"}, 64'(stall_o), 64'd1);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (stall_o) n++;
            else break;
        end
        chk({tag, " stall_cycles"}, 64'(n), 64'd33);
        chk({tag, " done_rvalid"}, 64'(result_valid_o), 64'(is_mul));
        if (is_mul) chk({tag, " done_result"}, 64'(result_o), 64'(exp_res));
        valid_i = 1'b0;
        op_i    = 3'd0;
        tick();
        chk({tag, " hilo"}, {hi_o, lo_o}, exp_hilo);
        chk({tag, " idle_stall"}, 64'(stall_o), 64'd0);
    endtask

    initial begin
        rst = 1'b0; valid_i = 1'b0; op_i = 3'd0;
        reg1_i = '0; reg2_i = '0; flush_i = 1'b0;
        #3;
        chk("reset stall", 64'(stall_o), 64'd0);
        chk("reset rvalid", 64'(result_valid_o), 64'd0);
        chk("reset result", 64'(result_o), 64'd0);
        chk("reset hilo", {hi_o, lo_o}, 64'd0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // op 0 with valid: nothing happens
        valid_i = 1'b1; op_i = 3'd0; reg1_i = 32'h5555_AAAA;
        #1;
        chk("nop stall", 64'(stall_o), 64'd0);
        chk("nop rvalid", 64'(result_valid_o), 64'd0);
        tick();
        valid_i = 1'b0;
        chk("nop hilo", {hi_o, lo_o}, 64'd0);

        run_mult("multu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 32'h0);
        run_mult("mult_m3x7", 3'd1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 32'h0);
        run_mult("mult_min2", 3'd1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 32'h0);
        run_mult("mult_minx1", 3'd1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, 1'b0, 32'h0);

        // MTHI/MTLO then MUL: MUL must leave HI/LO alone
        valid_i = 1'b1; op_i = 3'd4; reg1_i = 32'h1234_5678;
        tick();
        op_i = 3'd5; reg1_i = 32'h9ABC_DEF0;
        tick();
        valid_i = 1'b0;
        run_mult("mul", 3'd3, 32'h0001_0003, 32'h0001_0000, 64'h1234_5678_9ABC_DEF0, 1'b1, 32'h0003_0000);

        // MTHI at t, MFHI at t+1 sees the new value with no stall
        valid_i = 1'b1; op_i = 3'd4; reg1_i = 32'hDEAD_BEEF;
        #1;
        chk("mthi stall", 64'(stall_o), 64'd0);
        tick();
        op_i = 3'd6;
        #1;
        chk("mfhi rvalid", 64'(result_valid_o), 64'd1);
        chk("mfhi result", 64'(result_o), 64'hDEAD_BEEF);
        chk("mfhi stall", 64'(stall_o), 64'd0);
        tick();
        valid_i = 1'b0; op_i = 3'd0;
        #1;
        chk("hold rvalid", 64'(result_valid_o), 64'd0);
        chk("hold result", 64'(result_o), 64'hDEAD_BEEF);

        // Flush in IDLE drops an MTHI
        valid_i = 1'b1; op_i = 3'd4; reg1_i = 32'h0; flush_i = 1'b1;
        tick();
        valid_i = 1'b0; flush_i = 1'b0;
        chk("flush_mthi hi", 64'(hi_o), 64'hDEAD_BEEF);

        // Flush mid-RUN: stall drops next cycle, HI/LO untouched
        valid_i = 1'b1; op_i = 3'd4; reg1_i = 32'h1111_1111;
        tick();
        op_i = 3'd5; reg1_i = 32'h2222_2222;
        tick();
        op_i = 3'd7;
        #1;
        chk("mflo result", 64'(result_o), 64'h2222_2222);
        tick();
        op_i = 3'd2; reg1_i = 32'h0000_0005; reg2_i = 32'h0000_0007;
        for (int i = 0; i < 10; i++) tick();
        valid_i = 1'b0; op_i = 3'd0; flush_i = 1'b1;
        #1;
        chk("flush stall_in_cycle", 64'(stall_o), 64'd1);
        tick();
        flush_i = 1'b0;
        chk("flush stall_after", 64'(stall_o), 64'd0);
        for (int i = 0; i < 40; i++) tick();
        chk("flush hilo", {hi_o, lo_o}, 64'h1111_1111_2222_2222);
        chk("flush stall_late", 64'(stall_o), 64'd0);

        // Reset mid-RUN clears everything immediately
        valid_i = 1'b1; op_i = 3'd2; reg1_i = 32'h0000_0005; reg2_i = 32'h0000_0007;
        for (int i = 0; i < 10; i++) tick();
        valid_i = 1'b0; op_i = 3'd0;
        rst = 1'b0;
        #1;
        chk("rstrun stall", 64'(stall_o), 64'd0);
        chk("rstrun hilo", {hi_o, lo_o}, 64'd0);
        chk("rstrun result", 64'(result_o), 64'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        chk("rstrun hilo_late", {hi_o, lo_o}, 64'd0);
        chk("rstrun stall_late", 64'(stall_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
